subbytes_word_scheduler: RTL and testbench

//  Sequences one 32-bit word through a single shared, Hamming-protected S-box lane, one byte per cycle.

---
 rtl/aes_sbox_pkg.sv | 63 ++++++
 rtl/sbox_protected_lane.sv | 39 +++
 rtl/subbytes_word_scheduler.sv | 129 ++++++++++++
 tb/tb_subbytes_word_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared types, Hamming matrices and S-box math for the protected lane
// Purpose: FSM state type, codeword/syndrome widths, predictor and check matrices,
//          and the GF(2^8) helpers that implement the AES S-box.
// Ports:   none (package).
package aes_sbox_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW_W  = 12;
   localparam int SYN_W = 4;

   // Data-bit columns are the eight weight>=2 nibbles 3,5,6,7,9,A,B,C, so every
   // single-bit flip of the 12-bit codeword yields a distinct nonzero syndrome.
   // Row r selects the data bits whose column has bit r set.
   localparam logic [SYN_W-1:0][7:0] PRED_MATRIX = {
      8'hF0, 8'h8E, 8'h6D, 8'h5B
   };

   // Check matrix is [P | I4] laid out to match codeword {data[7:0], check[3:0]}.
   localparam logic [SYN_W-1:0][CW_W-1:0] CHECK_MATRIX = {
      12'hF08, 12'h8E4, 12'h6D2, 12'h5B1
   };

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = gf_xtime(t);
      end
      return p;
   endfunction

   // x^254 == x^-1 in GF(2^8); zero maps to zero as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = gf_mul(x, x);
      res = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] a;
      a = gf_inv(x);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/sbox_protected_lane.sv
// rtl/sbox_protected_lane.sv - one S-box lookup with Hamming check-bit prediction and syndrome check
// Purpose: combinational lane; the codeword {sbox_out, predicted check bits} is
//          XORed with inj_mask and run through the checker. The data output is
//          taken before the injection point, so injection only disturbs the check.
// Ports:   byte_in  - lane input byte
//          inj_mask - XOR pattern applied to the 12-bit codeword ahead of the checker
//          sbox_out - substituted byte
//          syndrome - 4-bit syndrome, zero when the codeword is consistent
module sbox_protected_lane
   import aes_sbox_pkg::*;
(
   input  logic [7:0]       byte_in,
   input  logic [CW_W-1:0]  inj_mask,
   output logic [7:0]       sbox_out,
   output logic [SYN_W-1:0] syndrome
);

   logic [SYN_W-1:0] pred;
   logic [CW_W-1:0]  cw;

   assign sbox_out = sbox(byte_in);

   always_comb begin
      pred = '0;
      for (int r = 0; r < SYN_W; r++) begin
         pred[r] = ^(PRED_MATRIX[r] & sbox_out);
      end
   end

   assign cw = {sbox_out, pred} ^ inj_mask;

   always_comb begin
      syndrome = '0;
      for (int r = 0; r < SYN_W; r++) begin
         syndrome[r] = ^(CHECK_MATRIX[r] & cw);
      end
   end

endmodule

// File: rtl/subbytes_word_scheduler.sv
// rtl/subbytes_word_scheduler.sv - serialises a 32-bit word through one protected S-box lane
// Purpose: accepts a word, pushes bytes 0..3 through the shared lane one per cycle,
//          retries a byte on nonzero syndrome up to MAX_RETRY times, then presents
//          the substituted word with per-byte fault flags.
// Ports:   clk, rst_n                   - clock, async active-low reset
//          in_valid/in_ready/in_word    - input word handshake
//          out_valid/out_ready/out_word - result handshake
//          out_err, out_fault_bytes     - any/per-byte retry exhaustion for out_word
//          busy                         - word in flight
//          inj_mask, inj_sticky         - fault injection into the lane checker
//          fault_count                  - saturating count of bytes that exhausted retries
module subbytes_word_scheduler
   import aes_sbox_pkg::*;
#(
   parameter int MAX_RETRY = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_word,
   output logic             out_err,
   output logic [3:0]       out_fault_bytes,
   output logic             busy,
   input  logic [CW_W-1:0]  inj_mask,
   input  logic             inj_sticky,
   output logic [CNT_W-1:0] fault_count
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   state_t             state;
   logic [1:0]         idx;
   logic [RETRY_W-1:0] retry;
   logic [31:0]        word_q;

   logic [7:0]         lane_in;
   logic [7:0]         lane_out;
   logic [CW_W-1:0]    lane_mask;
   logic [SYN_W-1:0]   syn;
   logic               accept;
   logic               syn_err;
   logic               at_limit;
   logic               give_up;
   logic               do_write;
   logic [3:0]         fault_next;

   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept    = in_valid & in_ready;

   assign lane_in   = word_q[{idx, 3'b000} +: 8];
   // Non-sticky injection only disturbs the first attempt so a retry can clear it.
   assign lane_mask = ((retry == '0) | inj_sticky) ? inj_mask : '0;

   sbox_protected_lane u_lane (
      .byte_in  (lane_in),
      .inj_mask (lane_mask),
      .sbox_out (lane_out),
      .syndrome (syn)
   );

   assign syn_err    = |syn;
   assign at_limit   = (retry == RETRY_W'(MAX_RETRY));
   assign give_up    = syn_err & at_limit;
   assign do_write   = ~syn_err | at_limit;
   assign fault_next = out_fault_bytes | (give_up ? (4'b0001 << idx) : 4'b0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         idx             <= '0;
         retry           <= '0;
         word_q          <= '0;
         out_word        <= '0;
         out_err         <= 1'b0;
         out_fault_bytes <= '0;
         fault_count     <= '0;
         out_valid       <= 1'b0;
         busy            <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  word_q          <= in_word;
                  idx             <= '0;
                  retry           <= '0;
                  out_fault_bytes <= '0;
                  out_err         <= 1'b0;
                  out_valid       <= 1'b0;
                  busy            <= 1'b1;
                  state           <= RUN;
               end else if ((state == DONE) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            RUN: begin
               if (do_write) begin
                  out_word[{idx, 3'b000} +: 8] <= lane_out;
                  out_fault_bytes              <= fault_next;
                  out_err                      <= |fault_next;
                  retry                        <= '0;
                  idx                          <= idx + 2'd1;
                  if (give_up && (fault_count != '1)) begin
                     fault_count <= fault_count + CNT_W'(1);
                  end
                  if (idx == 2'd3) begin
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  retry <= retry + RETRY_W'(1);
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subbytes_word_scheduler.sv
// tb/tb_subbytes_word_scheduler.sv - scoreboard bench for subbytes_word_scheduler
module tb_subbytes_word_scheduler;

   localparam int MAX_RETRY = 2;
   localparam int CNT_W     = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_word = 32'h0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_word;
   logic             out_err;
   logic [3:0]       out_fault_bytes;
   logic             busy;
   logic [11:0]      inj_mask = 12'h000;
   logic             inj_sticky = 1'b0;
   logic [CNT_W-1:0] fault_count;

   subbytes_word_scheduler #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_word         (in_word),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_word        (out_word),
      .out_err         (out_err),
      .out_fault_bytes (out_fault_bytes),
      .busy            (busy),
      .inj_mask        (inj_mask),
      .inj_sticky      (inj_sticky),
      .fault_count     (fault_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      word;
      logic             err;
      logic [3:0]       fb;
      logic [CNT_W-1:0] fc;
      int               lat;
      int               acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   seen  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares each result on the first cycle it is presented.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid && !seen) begin
         exp_t e;
         seen = 1'b1;
         if (sb_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("out_word", out_word, e.word);
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("out_fault_bytes", 32'(out_fault_bytes), 32'(e.fb));
            chk("fault_count", 32'(fault_count), 32'(e.fc));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end else if (!out_valid) begin
         seen = 1'b0;
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [31:0] w, input bit track, input logic [31:0] ew,
                       input logic ee, input logic [3:0] efb, input logic [CNT_W-1:0] efc,
                       input int elat);
      exp_t e;
      in_word  = w;
      in_valid = 1'b1;
      #1;
      chk("accept_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_word  = 32'hdeadbeef;
      if (track) begin
         e.word = ew; e.err = ee; e.fb = efb; e.fc = efc; e.lat = elat; e.acc = cyc;
         sb_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1 reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_word", out_word, 32'h0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_fault_bytes", 32'(out_fault_bytes), 32'd0);
      chk("rst_fault_count", 32'(fault_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 2 fault-free word
      send(32'h00010253, 1'b1, 32'h637c77ed, 1'b0, 4'h0, 16'd0, 4);
      drain();

      // 3 transient fault corrected by one retry per byte
      inj_mask = 12'h001; inj_sticky = 1'b0;
      send(32'hffffffff, 1'b1, 32'h16161616, 1'b0, 4'h0, 16'd0, 8);
      drain();

      // 4 persistent fault exhausts retries on every byte
      inj_mask = 12'h800; inj_sticky = 1'b1;
      send(32'h00000000, 1'b1, 32'h63636363, 1'b1, 4'hF, 16'd4, 12);
      drain();

      // 5 backpressure, then back-to-back accept
      inj_mask = 12'h000; inj_sticky = 1'b0;
      out_ready = 1'b0;
      send(32'h02020202, 1'b1, 32'h77777777, 1'b0, 4'h0, 16'd4, 4);
      for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_word_stable", out_word, 32'h77777777);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      send(32'h53535353, 1'b1, 32'hedededed, 1'b0, 4'h0, 16'd4, 4);
      drain();

      // 6 reset while the third byte is in the lane
      send(32'haaaaaaaa, 1'b0, 32'h0, 1'b0, 4'h0, 16'd0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_run_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_fault_count", 32'(fault_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("in_rst_out_valid", 32'(out_valid), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      send(32'h01010101, 1'b1, 32'h7c7c7c7c, 1'b0, 4'h0, 16'd0, 4);
      drain();
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
